bloom_ctrl: RTL and testbench

- Sequencer for the Bloom-filter custom instructions (INSERT, CHECK, CLEAR) issued from the EX stage.
- Accepts one request at a time and derives NUM_HASH bit indices from rs1 by double hashing.
- Runs read-modify-write or read-test sequences on a single-port, word-organised bit-array RAM, then returns a one-cycle response.
- After reset it sweeps the array to zero before accepting any request.

---
 rtl/bloom_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_bloom_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bloom_ctrl
//
// Sequencer for the Bloom-filter custom instructions issued from EX:
//   INSERT (op 00) : set NUM_HASH bits derived from rs1
//   CHECK  (op 01) : test those bits, result 1 only if all are set
//   CLEAR  (op 10) : zero the whole bit array
//   op 11          : illegal, answered immediately with resp_err_o
//
// The bit array lives in an external single-port RAM of NUM_WORDS 32-bit
// words. Its read data arrives the cycle after the read strobe, and a write
// is visible to a read strobe issued on the following cycle.
//
// Bit indices use double hashing:
//   h1 = rs1[B-1:0] ^ rs1[31:32-B], h2 = rs1[B+7:8] | 1
//   idx_0 = h1, idx_k+1 = idx_k + h2 (mod 2^B)
// The word address is idx[B-1:5] and the bit within the word is idx[4:0].
//
// After reset the controller sweeps the array to zero. It accepts no request
// until the sweep is done.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake, accepted when both are high
//   op_i, rs1_i          opcode and element, sampled only at accept
//   resp_valid_o         one-cycle completion pulse, no backpressure
//   resp_result_o        CHECK match flag in bit 0, zero for all other ops
//   resp_err_o           high with resp_valid_o for an illegal opcode
//   mem_req_o/we_o       RAM strobe and write enable
//   mem_addr_o           RAM word address
//   mem_wdata_o          RAM write data
//   mem_rdata_i          RAM read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module bloom_ctrl #(
  parameter int BITS_LOG2 = 10,
  parameter int NUM_HASH  = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           op_i,
  input  logic [31:0]          rs1_i,
  output logic                 resp_valid_o,
  output logic [31:0]          resp_result_o,
  output logic                 resp_err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [BITS_LOG2-6:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);

  localparam int AW        = BITS_LOG2 - 5;
  localparam int NUM_WORDS = 1 << AW;
  localparam int WC_W      = AW + 1;
  localparam int HC_W      = 4;

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_CHECK  = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    IDLE = 3'd1,
    RD   = 3'd2,
    MOD  = 3'd3,
    TST  = 3'd4,
    CLR  = 3'd5,
    DONE = 3'd6
  } state_t;

  // State and capture registers
  state_t              state_reg, state_next;
  logic [WC_W-1:0]     wcnt_reg, wcnt_next;
  logic [1:0]          op_reg, op_next;
  logic [BITS_LOG2-1:0] h2_reg, h2_next;
  logic [BITS_LOG2-1:0] idx_reg, idx_next;
  logic [HC_W-1:0]     hcnt_reg, hcnt_next;

  // Registered outputs
  logic                ready_reg, ready_next;
  logic                resp_valid_reg, resp_valid_next;
  logic                result_reg, result_next;
  logic                err_reg, err_next;
  logic                mem_req_reg, mem_req_next;
  logic                mem_we_reg, mem_we_next;
  logic [AW-1:0]       mem_addr_reg, mem_addr_next;

  // Hashes of the incoming element, used only in the accept cycle
  logic [BITS_LOG2-1:0] acc_h1;
  logic [BITS_LOG2-1:0] acc_h2;
  assign acc_h1 = rs1_i[BITS_LOG2-1:0] ^ rs1_i[31:32-BITS_LOG2];
  assign acc_h2 = rs1_i[BITS_LOG2+7:8] | BITS_LOG2'(1);

  // Some rs1 bits feed neither hash for smaller filters.
  logic unused_rs1;
  assign unused_rs1 = ^rs1_i;

  // Next index in the double-hash sequence; wraps at 2^BITS_LOG2 by width.
  logic [BITS_LOG2-1:0] idx_adv;
  assign idx_adv = idx_reg + h2_reg;

  logic last_hash;
  assign last_hash = (hcnt_reg == HC_W'(NUM_HASH - 1));

  logic sweep_done;
  assign sweep_done = (wcnt_reg == WC_W'(NUM_WORDS));

  // One-hot mask of the selected bit within the current word
  logic [31:0] bit_mask;
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_mask
      assign bit_mask[gi] = (idx_reg[4:0] == 5'(gi));
    end
  endgenerate

  // In TST the word read during RD is on mem_rdata_i.
  logic bit_set;
  assign bit_set = |(mem_rdata_i & bit_mask);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= INIT;
      wcnt_reg       <= '0;
      op_reg         <= '0;
      h2_reg         <= '0;
      idx_reg        <= '0;
      hcnt_reg       <= '0;
      ready_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;
      result_reg     <= 1'b0;
      err_reg        <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      wcnt_reg       <= wcnt_next;
      op_reg         <= op_next;
      h2_reg         <= h2_next;
      idx_reg        <= idx_next;
      hcnt_reg       <= hcnt_next;
      ready_reg      <= ready_next;
      resp_valid_reg <= resp_valid_next;
      result_reg     <= result_next;
      err_reg        <= err_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic.
  // The output registers are loaded with the values for the state being
  // entered, so they match state_reg throughout each cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    wcnt_next       = wcnt_reg;
    op_next         = op_reg;
    h2_next         = h2_reg;
    idx_next        = idx_reg;
    hcnt_next       = hcnt_reg;
    ready_next      = 1'b0;
    resp_valid_next = 1'b0;
    result_next     = 1'b0;
    err_next        = 1'b0;
    mem_req_next    = 1'b0;
    mem_we_next     = 1'b0;
    mem_addr_next   = '0;

    case (state_reg)
      // Zero sweep. wcnt counts the words already issued. The write for word
      // wcnt is loaded here and appears on the bus in the next cycle.
      INIT, CLR: begin
        if (sweep_done) begin
          wcnt_next = '0;
          if (state_reg == INIT) begin
            state_next = IDLE;
            ready_next = 1'b1;
          end else begin
            state_next      = DONE;
            resp_valid_next = 1'b1;
          end
        end else begin
          mem_req_next  = 1'b1;
          mem_we_next   = 1'b1;
          mem_addr_next = wcnt_reg[AW-1:0];
          wcnt_next     = wcnt_reg + 1'b1;
        end
      end

      IDLE: begin
        ready_next = 1'b1;
        if (req_valid_i) begin
          ready_next = 1'b0;
          op_next    = op_i;
          h2_next    = acc_h2;
          idx_next   = acc_h1;
          hcnt_next  = '0;
          case (op_i)
            OP_INSERT, OP_CHECK: begin
              state_next    = RD;
              mem_req_next  = 1'b1;
              mem_addr_next = acc_h1[BITS_LOG2-1:5];
            end
            OP_CLEAR: begin
              // Word 0 goes out in the first CLR cycle, so the sweep takes
              // exactly NUM_WORDS cycles.
              state_next    = CLR;
              mem_req_next  = 1'b1;
              mem_we_next   = 1'b1;
              mem_addr_next = '0;
              wcnt_next     = WC_W'(1);
            end
            default: begin
              state_next      = DONE;
              resp_valid_next = 1'b1;
              err_next        = 1'b1;
            end
          endcase
        end
      end

      // A read strobe is on the bus this cycle. INSERT follows it with a
      // write to the same word. CHECK waits one cycle for the read data.
      RD: begin
        if (op_reg == OP_INSERT) begin
          state_next    = MOD;
          mem_req_next  = 1'b1;
          mem_we_next   = 1'b1;
          mem_addr_next = idx_reg[BITS_LOG2-1:5];
        end else begin
          state_next = TST;
        end
      end

      MOD: begin
        if (last_hash) begin
          state_next      = DONE;
          resp_valid_next = 1'b1;
        end else begin
          state_next    = RD;
          idx_next      = idx_adv;
          hcnt_next     = hcnt_reg + 1'b1;
          mem_req_next  = 1'b1;
          mem_addr_next = idx_adv[BITS_LOG2-1:5];
        end
      end

      // A clear bit settles the CHECK at once. No further reads are issued.
      TST: begin
        if (!bit_set) begin
          state_next      = DONE;
          resp_valid_next = 1'b1;
        end else if (last_hash) begin
          state_next      = DONE;
          resp_valid_next = 1'b1;
          result_next     = 1'b1;
        end else begin
          state_next    = RD;
          idx_next      = idx_adv;
          hcnt_next     = hcnt_reg + 1'b1;
          mem_req_next  = 1'b1;
          mem_addr_next = idx_adv[BITS_LOG2-1:5];
        end
      end

      DONE: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end

      default: begin
        state_next = INIT;
        wcnt_next  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready_o   = ready_reg;
  assign resp_valid_o  = resp_valid_reg;
  assign resp_result_o = {31'b0, result_reg};
  assign resp_err_o    = err_reg;
  assign mem_req_o     = mem_req_reg;
  assign mem_we_o      = mem_we_reg;
  assign mem_addr_o    = mem_addr_reg;

  // The MOD write merges the bit into the word the RAM returns in this same
  // cycle, so the write data cannot be registered. Sweeps write zero.
  assign mem_wdata_o = (state_reg == MOD) ? (mem_rdata_i | bit_mask) : 32'h0;

endmodule

// File: tb/tb_bloom_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bloom_ctrl
//
// Self-checking bench for bloom_ctrl (BITS_LOG2=10, NUM_HASH=3).
// - Holds the word RAM that the DUT drives. Reads are registered and writes
//   are visible to the next access.
// - Keeps a reference bit array updated from the operation rules: hash
//   arithmetic, set bits, test bits, clear all.
// - Compares the result, error flag, latency and RAM access count of each
//   response, and compares the RAM contents after each transaction.
// - Runs directed cases first, then randomized ones.
// -----------------------------------------------------------------------------
module tb_bloom_ctrl;

  localparam int BITS_LOG2 = 10;
  localparam int NUM_HASH  = 3;
  localparam int AW        = BITS_LOG2 - 5;
  localparam int NUM_WORDS = 1 << AW;
  localparam int FBITS     = 1 << BITS_LOG2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [1:0]    op_i;
  logic [31:0]   rs1_i;
  logic          resp_valid_o;
  logic [31:0]   resp_result_o;
  logic          resp_err_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;

  always #5 clk_i = ~clk_i;

  bloom_ctrl #(
    .BITS_LOG2 (BITS_LOG2),
    .NUM_HASH  (NUM_HASH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .op_i          (op_i),
    .rs1_i         (rs1_i),
    .resp_valid_o  (resp_valid_o),
    .resp_result_o (resp_result_o),
    .resp_err_o    (resp_err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  // Single-port word RAM with registered read data
  logic [31:0] ram [NUM_WORDS];
  logic [31:0] rdata_q;
  assign mem_rdata_i = rdata_q;

  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          rdata_q         <= ram[mem_addr_o];
    end
  end

  // Reference filter contents, one entry per filter bit
  bit mbits [FBITS];

  int n_checks = 0;
  int n_errors = 0;

  // Writes seen during the most recent transaction
  logic [31:0] wr_data_q [$];
  int          wr_addr_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Applies one operation to the reference array. Returns the expected
  // latency (accept edge to response), the number of RAM accesses, and the
  // expected result and error flag.
  task automatic model_op(input logic [1:0] op, input logic [31:0] rs1,
                          output int lat, output int acc,
                          output logic [31:0] res, output logic err);
    int h1, h2, idx, j;
    h1  = int'((rs1 % FBITS) ^ (rs1 >> (32 - BITS_LOG2)));
    h2  = int'(((rs1 >> 8) % FBITS) | 1);
    res = 32'd0;
    err = 1'b0;
    case (op)
      2'b00: begin
        idx = h1;
        for (int i = 0; i < NUM_HASH; i++) begin
          mbits[idx] = 1'b1;
          idx = (idx + h2) % FBITS;
        end
        lat = 2 * NUM_HASH + 1;
        acc = 2 * NUM_HASH;
      end
      2'b01: begin
        idx = h1;
        j   = 0;
        res = 32'd1;
        for (int i = 0; i < NUM_HASH; i++) begin
          j++;
          if (!mbits[idx]) begin
            res = 32'd0;
            break;
          end
          idx = (idx + h2) % FBITS;
        end
        lat = 2 * j + 1;
        acc = j;
      end
      2'b10: begin
        for (int i = 0; i < FBITS; i++) mbits[i] = 1'b0;
        lat = NUM_WORDS + 1;
        acc = NUM_WORDS;
      end
      default: begin
        lat = 1;
        acc = 0;
        err = 1'b1;
      end
    endcase
  endtask

  task automatic check_ram(input string tag);
    for (int w = 0; w < NUM_WORDS; w++) begin
      logic [31:0] e;
      e = '0;
      for (int b = 0; b < 32; b++) e[b] = mbits[w * 32 + b];
      check($sformatf("%s_ram%0d", tag, w), ram[w], e);
    end
  endtask

  // Call at a falling edge just after reset is released. Checks the zero
  // sweep cycle by cycle and then the rise of ready.
  task automatic check_sweep(input string tag);
    for (int k = 0; k < NUM_WORDS; k++) begin
      @(negedge clk_i);
      check($sformatf("%s_ctl%0d", tag, k),
            32'({mem_req_o, mem_we_o, req_ready_o, resp_valid_o}), 32'b1100);
      check($sformatf("%s_addr%0d", tag, k), 32'(mem_addr_o), 32'(k));
      check($sformatf("%s_wdata%0d", tag, k), mem_wdata_o, 32'h0);
    end
    @(negedge clk_i);
    check({tag, "_ready"}, 32'({req_ready_o, mem_req_o, resp_valid_o}), 32'b100);
    $display("txn %s sweep of %0d words", tag, NUM_WORDS);
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] rs1,
                       output int lat_o, output logic [31:0] res_o);
    int          exp_lat, exp_acc, guard, m, nacc;
    logic [31:0] exp_res;
    logic        exp_err;
    bit          stray;
    model_op(op, rs1, exp_lat, exp_acc, exp_res, exp_err);
    guard = 0;
    while (!req_ready_o && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    check({tag, "_rdy"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    op_i        = op;
    rs1_i       = rs1;
    @(posedge clk_i);
    @(negedge clk_i);
    m     = 0;
    nacc  = 0;
    stray = 1'b0;
    wr_data_q.delete();
    wr_addr_q.delete();
    while (!resp_valid_o && m < 200) begin
      if (mem_req_o) begin
        nacc++;
        if (mem_we_o) begin
          wr_data_q.push_back(mem_wdata_o);
          wr_addr_q.push_back(int'(mem_addr_o));
        end
      end
      if (resp_result_o != 32'd0 || resp_err_o || req_ready_o) stray = 1'b1;
      // These inputs arrive while the controller is busy and must be ignored.
      req_valid_i = 1'($urandom);
      op_i        = 2'($urandom);
      rs1_i       = $urandom;
      @(negedge clk_i);
      m++;
    end
    req_valid_i = 1'b0;
    check({tag, "_resp"}, 32'(resp_valid_o), 32'd1);
    check({tag, "_lat"}, 32'(m + 1), 32'(exp_lat));
    check({tag, "_result"}, resp_result_o, exp_res);
    check({tag, "_err"}, 32'(resp_err_o), 32'(exp_err));
    check({tag, "_nacc"}, 32'(nacc), 32'(exp_acc));
    check({tag, "_quiet"}, 32'({stray, mem_req_o, req_ready_o}), 32'd0);
    lat_o = m + 1;
    res_o = resp_result_o;
    $display("txn %s op=%0d rs1=%08h lat=%0d result=%0d err=%0d accesses=%0d",
             tag, op, rs1, m + 1, resp_result_o, resp_err_o, nacc);
    @(negedge clk_i);
    check({tag, "_pulse"}, 32'({resp_valid_o, req_ready_o}), 32'b01);
    check_ram(tag);
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic [31:0] ins_q [$];

    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    op_i        = 2'b00;
    rs1_i       = 32'h0;
    for (int i = 0; i < NUM_WORDS; i++) ram[i] = $urandom;

    repeat (3) @(negedge clk_i);
    check("rst_ready",   32'(req_ready_o),  32'd0);
    check("rst_resp",    32'(resp_valid_o), 32'd0);
    check("rst_result",  resp_result_o,     32'd0);
    check("rst_err",     32'(resp_err_o),   32'd0);
    check("rst_memreq",  32'(mem_req_o),    32'd0);
    check("rst_memwe",   32'(mem_we_o),     32'd0);
    check("rst_memaddr", 32'(mem_addr_o),   32'd0);
    check("rst_wdata",   mem_wdata_o,       32'd0);

    rst_ni = 1'b1;
    check_sweep("init");
    check_ram("init");

    // INSERT 0: indices 0,1,2 all in word 0
    do_op("ins0", 2'b00, 32'h0, lat, res);
    check("ins0_lat7", 32'(lat), 32'd7);
    check("ins0_nwr", 32'(wr_data_q.size()), 32'd3);
    check("ins0_wd0", wr_data_q[0], 32'h1);
    check("ins0_wd1", wr_data_q[1], 32'h3);
    check("ins0_wd2", wr_data_q[2], 32'h7);
    check("ins0_wa2", 32'(wr_addr_q[2]), 32'd0);

    do_op("chk0", 2'b01, 32'h0, lat, res);
    check("chk0_lat7", 32'(lat), 32'd7);
    check("chk0_hit", res, 32'd1);

    // h1 = 512, word 16 is empty: early exit after one read
    do_op("chk200", 2'b01, 32'h200, lat, res);
    check("chk200_lat3", 32'(lat), 32'd3);
    check("chk200_miss", res, 32'd0);

    // INSERT 0x100 interrupted by reset in its MOD cycle
    while (!req_ready_o) @(negedge clk_i);
    req_valid_i = 1'b1;
    op_i        = 2'b00;
    rs1_i       = 32'h100;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("abort_rd", 32'({mem_req_o, mem_we_o}), 32'b10);
    @(negedge clk_i);
    check("abort_mod", 32'({mem_req_o, mem_we_o, mem_addr_o}), 32'({2'b11, 5'd8}));
    rst_ni = 1'b0;
    #1;
    check("abort_async", 32'({mem_req_o, req_ready_o, resp_valid_o}), 32'd0);
    @(negedge clk_i);
    check("abort_noresp", 32'(resp_valid_o), 32'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < FBITS; i++) mbits[i] = 1'b0;
    check_sweep("reinit");
    check_ram("reinit");

    do_op("chk100", 2'b01, 32'h100, lat, res);
    check("chk100_miss", res, 32'd0);

    do_op("illegal", 2'b11, 32'h1234_5678, lat, res);
    check("ill_lat1", 32'(lat), 32'd1);
    check("ill_nacc", 32'(wr_data_q.size()), 32'd0);

    do_op("ins_pre", 2'b00, 32'hdead_beef, lat, res);
    do_op("clr", 2'b10, 32'h0, lat, res);
    check("clr_lat33", 32'(lat), 32'd33);
    check("clr_nwr", 32'(wr_data_q.size()), 32'd32);
    do_op("chk_after_clr", 2'b01, 32'hdead_beef, lat, res);

    // Randomized mix. Small operands make index collisions more likely, and
    // re-checking inserted values exercises the all-hit path.
    for (int t = 0; t < 80; t++) begin
      int          r;
      logic [1:0]  op;
      logic [31:0] v;
      r  = int'($urandom_range(0, 99));
      op = (r < 40) ? 2'b00 : (r < 80) ? 2'b01 : (r < 86) ? 2'b10 : 2'b11;
      v  = $urandom;
      if ($urandom_range(0, 3) == 0) v = v & 32'h0000_0fff;
      if (op == 2'b01 && ins_q.size() > 0 && $urandom_range(0, 1) == 1)
        v = ins_q[$urandom_range(0, ins_q.size() - 1)];
      if (op == 2'b00) ins_q.push_back(v);
      do_op($sformatf("rnd%0d", t), op, v, lat, res);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
